// File: rtl/temp_sensor_pkg.sv
// Shared widths and the sequencer state encoding for the temperature sensor
// sequencer / averager.
package temp_sensor_pkg;
  localparam int DOUT_W = 24;
  localparam int ACC_W  = 31;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_DONE,
    ST_CAPTURE,
    ST_OUT
  } state_e;
endpackage

// File: rtl/temp_done_sync.sv
// Brings the asynchronous sensor DONE level into the CLK_REF domain and
// produces a single-cycle pulse on its rising edge.
module temp_done_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/temp_sensor_seq_avg.sv
// Sequences the temperature sensor macro (enable, counter reset, wait for
// DONE), averages 2^win_log2 conversions and publishes the result.
module temp_sensor_seq_avg
  import temp_sensor_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              CLK_REF,
  input  logic              RESET,
  input  logic              enable,
  input  logic [2:0]        avg_log2,
  input  logic [DOUT_W-1:0] thresh_hi,
  input  logic [DOUT_W-1:0] sens_dout,
  input  logic              sens_done,
  output logic              sens_en,
  output logic              sens_reset_n,
  output logic [DOUT_W-1:0] avg_dout,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              alarm,
  output logic              timeout_err,
  output logic              busy
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CYC_W = (TO_W > 4) ? TO_W : 4;
  localparam logic [CYC_W-1:0] ARM_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        win_q, win_d;
  logic [DOUT_W-1:0] avg_dout_q, avg_dout_d;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;
  logic              timeout_err_q, timeout_err_d;

  logic              done_rise;
  logic [ACC_W-1:0]  acc_sum;
  logic [DOUT_W-1:0] avg_next;
  logic [CNT_W-1:0]  cnt_inc;

  temp_done_sync #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .clk  (CLK_REF),
    .rst  (RESET),
    .din  (sens_done),
    .rise (done_rise)
  );

  // avg_valid/avg_ready: a result transfers on any cycle where both are high.
  // Once raised, avg_valid and avg_dout stay fixed until that transfer, and
  // no new conversion starts meanwhile, so backpressure never drops data.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    win_d         = win_q;
    avg_dout_d    = avg_dout_q;
    avg_valid_d   = avg_valid_q;
    alarm_d       = alarm_q;
    timeout_err_d = timeout_err_q;
    acc_sum       = acc_q + ACC_W'(sens_dout);
    avg_next      = DOUT_W'(acc_sum >> win_q);
    cnt_inc       = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          win_d   = avg_log2;
          acc_d   = '0;
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cyc_q == ARM_LAST) begin
          cyc_d   = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise) begin
          cyc_d   = '0;
          state_d = ST_CAPTURE;
        end else if (cyc_q == TO_LAST) begin
          // A lost conversion poisons the window, so restart it from scratch.
          timeout_err_d = 1'b1;
          acc_d         = '0;
          cnt_d         = '0;
          cyc_d         = '0;
          state_d       = ST_ARM;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_CAPTURE: begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == (CNT_W'(1) << win_q)) begin
          avg_dout_d  = avg_next;
          alarm_d     = (avg_next >= thresh_hi);
          avg_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_OUT: begin
        if (avg_ready) begin
          avg_valid_d = 1'b0;
          win_d       = avg_log2;
          acc_d       = '0;
          cnt_d       = '0;
          cyc_d       = '0;
          state_d     = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !enable) begin
      state_d       = ST_IDLE;
      acc_d         = '0;
      cnt_d         = '0;
      cyc_d         = '0;
      avg_valid_d   = 1'b0;
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_REF) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      win_q         <= '0;
      avg_dout_q    <= '0;
      avg_valid_q   <= 1'b0;
      alarm_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      win_q         <= win_d;
      avg_dout_q    <= avg_dout_d;
      avg_valid_q   <= avg_valid_d;
      alarm_q       <= alarm_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sens_en      = (state_q != ST_IDLE);
  assign sens_reset_n = (state_q == ST_WAIT_DONE) || (state_q == ST_CAPTURE) ||
                        (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign avg_dout     = avg_dout_q;
  assign avg_valid    = avg_valid_q;
  assign alarm        = alarm_q;
  assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_temp_sensor_seq_avg.sv
// Directed bench for temp_sensor_seq_avg: behavioural sensor model, an
// expected-result queue and a monitor that scores every published average.
module tb_temp_sensor_seq_avg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  avg_log2 = 3'd0;
  logic [23:0] thresh_hi = 24'hFFFFFF;
  logic [23:0] sens_dout = 24'd0;
  logic        sens_done = 1'b0;
  logic        avg_ready = 1'b1;
  logic        sens_en, sens_reset_n, avg_valid, alarm, timeout_err, busy;
  logic [23:0] avg_dout;

  int checks = 0;
  int errors = 0;
  int pub_count = 0;
  int sens_lat = 6;
  int sens_cnt = 0;
  logic [24:0] exp_q[$];
  logic [23:0] sens_q[$];

  always #5 clk = ~clk;

  temp_sensor_seq_avg #(
    .RST_CYCLES(4), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)
  ) dut (
    .CLK_REF(clk), .RESET(rst), .enable(enable), .avg_log2(avg_log2),
    .thresh_hi(thresh_hi), .sens_dout(sens_dout), .sens_done(sens_done),
    .sens_en(sens_en), .sens_reset_n(sens_reset_n), .avg_dout(avg_dout),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .alarm(alarm),
    .timeout_err(timeout_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_exp_empty(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d results still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    sens_q.delete();
  endtask

  // Sensor model: DONE drops while the counter reset is low; after sens_lat
  // enabled cycles it raises DONE with the next queued value held on DOUT.
  always begin
    @(posedge clk);
    #1;
    if (!sens_reset_n) begin
      sens_done = 1'b0;
      sens_cnt  = 0;
    end else if (sens_en && !sens_done && sens_q.size() > 0) begin
      sens_cnt++;
      if (sens_cnt >= sens_lat) begin
        sens_dout = sens_q.pop_front();
        sens_done = 1'b1;
      end
    end
  end

  // Monitor: scores each accepted result against the expected queue.
  initial begin
    logic       pv;
    logic [24:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (avg_valid && !pv) pub_count++;
      pv = avg_valid;
      if (avg_valid && avg_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pub: got 0x%0h, expected no result", {alarm, avg_dout});
        end else begin
          e = exp_q.pop_front();
          check("pub_alarm_dout", {7'd0, alarm, avg_dout}, {7'd0, e});
        end
      end
    end
  end

  initial begin
    int n;
    int bad;
    int base;
    repeat (3) @(negedge clk);
    check("reset_outputs", {7'd0, sens_en, sens_reset_n, avg_valid, alarm, timeout_err, busy, avg_dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {30'd0, busy, sens_en}, 32'd0);

    // 1: single-sample average, arm length and DONE-to-valid latency
    sens_lat = 50; thresh_hi = 24'hFFFFFF; avg_log2 = 3'd0;
    sens_q.push_back(24'h001234);
    exp_q.push_back({1'b0, 24'h001234});
    enable = 1'b1;
    n = 0;
    while (!sens_en && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (sens_en && !sens_reset_n && n < 20) begin n++; @(negedge clk); end
    check("arm_low_cycles", n, 4);
    n = 0;
    while (!sens_done && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!avg_valid && n < 20) begin @(negedge clk); n++; end
    check("done_to_valid_latency", n, 4);
    wait_exp_empty(20, "t1_pub");
    check("rearm_after_accept", {29'd0, avg_valid, sens_reset_n, sens_en}, 32'b001);
    stop_run();

    // 2: four-sample window, exactly one publish
    sens_lat = 6; avg_log2 = 3'd2;
    sens_q.push_back(24'd100); sens_q.push_back(24'd101);
    sens_q.push_back(24'd102); sens_q.push_back(24'd104);
    exp_q.push_back({1'b0, 24'd101});
    base = pub_count;
    enable = 1'b1;
    wait_exp_empty(2000, "t2_pub");
    repeat (10) @(negedge clk);
    check("t2_one_pub", pub_count - base, 1);
    stop_run();

    // 3: alarm threshold boundary and backpressure stall
    thresh_hi = 24'h000800; avg_log2 = 3'd0;
    sens_q.push_back(24'h0007FF); sens_q.push_back(24'h000800);
    exp_q.push_back({1'b0, 24'h0007FF}); exp_q.push_back({1'b1, 24'h000800});
    enable = 1'b1;
    n = 0;
    while (exp_q.size() > 1 && n < 500) begin @(negedge clk); n++; end
    avg_ready = 1'b0;
    n = 0;
    while (!avg_valid && n < 500) begin @(negedge clk); n++; end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(avg_valid && sens_reset_n && avg_dout == 24'h000800 && alarm)) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_pending", exp_q.size(), 1);
    avg_ready = 1'b1;
    wait_exp_empty(20, "t3_pub");
    stop_run();
    check("hold_after_stop", {6'd0, avg_valid, alarm, avg_dout}, {8'b01, 24'h000800});

    // 4: timeout, window restart, sticky error; mid-window avg_log2 ignored
    thresh_hi = 24'hFFFFFF; avg_log2 = 3'd0;
    enable = 1'b1;
    n = 0;
    while (!sens_reset_n && n < 20) begin @(negedge clk); n++; end
    avg_log2 = 3'd2;
    n = 1;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      if (!timeout_err) n++;
    end
    check("timeout_cycle", n, 64);
    check("timeout_rearm", {29'd0, timeout_err, sens_reset_n, sens_en}, 32'b101);
    sens_q.push_back(24'h000ABC);
    exp_q.push_back({1'b0, 24'h000ABC});
    wait_exp_empty(200, "t4_pub");
    check("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // 5: drop enable mid-window, then a fresh window
    sens_q.push_back(24'd5); sens_q.push_back(24'd6);
    n = 0;
    while (sens_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (14) @(negedge clk);
    check("t5_waiting_before_drop", {30'd0, busy, sens_reset_n}, 32'b11);
    enable = 1'b0;
    @(negedge clk);
    check("drop_to_idle", {28'd0, busy, sens_en, timeout_err, avg_valid}, 32'd0);
    sens_q.push_back(24'd8); sens_q.push_back(24'd8);
    sens_q.push_back(24'd8); sens_q.push_back(24'd12);
    exp_q.push_back({1'b0, 24'd9});
    enable = 1'b1;
    wait_exp_empty(2000, "t5_pub");
    stop_run();

    // 6: 128 full-scale samples, then reset mid-window
    sens_lat = 3; avg_log2 = 3'd7; thresh_hi = 24'h000800;
    for (int i = 0; i < 128; i++) sens_q.push_back(24'hFFFFFF);
    exp_q.push_back({1'b1, 24'hFFFFFF});
    enable = 1'b1;
    wait_exp_empty(6000, "t6_pub");
    for (int i = 0; i < 10; i++) sens_q.push_back(24'hFFFFFF);
    n = 0;
    while (sens_q.size() > 5 && n < 500) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_window", {7'd0, sens_en, sens_reset_n, avg_valid, alarm, timeout_err, busy, avg_dout}, 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    sens_q.delete();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
